cbm_window_decoder: RTL and testbench

//  Parametrised successor to the CBM hidden-state decoder, for the reservoir network decode path.

---
 rtl/cbm_window_decoder.sv | 156 +++++++++++++++
 tb/tb_cbm_window_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cbm_window_decoder.sv
// CBM window decoder: integrates per-neuron 2-bit CBM codes over NT accepted beats,
// decodes each count to a WR-bit uni/bipolar value and queues result words in a small FIFO.
module cbm_window_decoder #(
    parameter int unsigned NH     = 8,
    parameter int unsigned WR     = 8,
    parameter int unsigned LOG_NT = 6,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned DEPTH  = 2
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AS_HiddenState,
    output logic             oReady_AS_HiddenState,
    input  logic [NH*2-1:0]  iData_AS_HiddenState,
    input  logic             iFlush,
    output logic             oValid_BM_DeHiddenState,
    input  logic             iReady_BM_DeHiddenState,
    output logic [NH*WR-1:0] oData_BM_DeHiddenState
);

    localparam int unsigned NT   = 1 << LOG_NT;
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FillW = $clog2(DEPTH + 1);
    localparam int unsigned ShU  = (WR > LOG_NT) ? WR - LOG_NT : 0;
    localparam int unsigned ShS  = (WR > LOG_NT + 1) ? WR - 1 - LOG_NT : 0;

    typedef enum logic {Accum, Push} stateType;

    stateType          stateQ;
    logic              readyQ;
    logic [LOG_NT-1:0] beatQ;
    logic [LOG_NT:0]   cntQ [NH];

    logic [NH*WR-1:0]  mem [DEPTH];
    logic [PtrW-1:0]   rdPtr;
    logic [PtrW-1:0]   wrPtr;
    logic [FillW-1:0]  fill;

    logic              accept;
    logic              lastBeat;
    logic              full;
    logic              pop;
    logic              pushWord;
    logic [NH-1:0]     hit;
    logic [NH*WR-1:0]  decoded;

    // Flush blocks acceptance in its own cycle.
    assign oReady_AS_HiddenState   = readyQ && !iFlush;
    assign accept                  = iValid_AS_HiddenState && oReady_AS_HiddenState;
    assign lastBeat                = (beatQ == LOG_NT'(NT - 1));
    assign full                    = (fill == FillW'(DEPTH));
    assign oValid_BM_DeHiddenState = (fill != '0);
    assign pop                     = oValid_BM_DeHiddenState && iReady_BM_DeHiddenState;
    // A same-edge pop frees the slot when full, so PUSH never bubbles.
    assign pushWord                = (stateQ == Push) && !iFlush && (!full || pop);
    assign oData_BM_DeHiddenState  = oValid_BM_DeHiddenState ? mem[rdPtr] : '0;

    always_comb begin
        hit = '0;
        for (int n = 0; n < NH; n++) begin
            hit[n] = iData_AS_HiddenState[2*n+1] ^ iData_AS_HiddenState[2*n];
        end
    end

    always_comb begin
        logic [WR-1:0] dec;
        logic [WR+1:0] wide;
        logic [WR+1:0] diff;
        decoded = '0;
        for (int n = 0; n < NH; n++) begin
            dec  = '0;
            wide = (WR+2)'(cntQ[n]);
            diff = (wide << 1) - (WR+2)'(NT);
            if (SIGNED == 0) begin
                if (cntQ[n] == (LOG_NT+1)'(NT)) begin
                    dec = '1;
                end else begin
                    dec = WR'(cntQ[n][LOG_NT-1:0]) << ShU;
                end
            end else begin
                // Full count saturates to the largest positive value.
                if (cntQ[n] == (LOG_NT+1)'(NT)) begin
                    dec = {1'b0, {(WR-1){1'b1}}};
                end else begin
                    dec = diff[WR-1:0] << ShS;
                end
            end
            decoded[WR*n +: WR] = dec;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            stateQ <= Accum;
            readyQ <= 1'b1;
            beatQ  <= '0;
            for (int n = 0; n < NH; n++) cntQ[n] <= '0;
        end else if (iFlush) begin
            stateQ <= Accum;
            readyQ <= 1'b1;
            beatQ  <= '0;
            for (int n = 0; n < NH; n++) cntQ[n] <= '0;
        end else begin
            unique case (stateQ)
                Accum: begin
                    if (accept) begin
                        for (int n = 0; n < NH; n++) begin
                            cntQ[n] <= cntQ[n] + (LOG_NT+1)'(hit[n]);
                        end
                        if (lastBeat) begin
                            stateQ <= Push;
                            readyQ <= 1'b0;
                        end else begin
                            beatQ <= beatQ + LOG_NT'(1);
                        end
                    end
                end
                Push: begin
                    if (pushWord) begin
                        stateQ <= Accum;
                        readyQ <= 1'b1;
                        beatQ  <= '0;
                        for (int n = 0; n < NH; n++) cntQ[n] <= '0;
                    end
                end
                default: begin
                    stateQ <= Accum;
                    readyQ <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rdPtr <= '0;
            wrPtr <= '0;
            fill  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pushWord) begin
                mem[wrPtr] <= decoded;
                wrPtr      <= (wrPtr == PtrW'(DEPTH - 1)) ? '0 : wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtr <= (rdPtr == PtrW'(DEPTH - 1)) ? '0 : rdPtr + PtrW'(1);
            end
            case ({pushWord, pop})
                2'b10:   fill <= fill + FillW'(1);
                2'b01:   fill <= fill - FillW'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: tb/tb_cbm_window_decoder.sv
// Scoreboard bench for cbm_window_decoder: one unipolar and one bipolar instance,
// expected words queued as windows are driven and compared as they leave the FIFO.
module tb_cbm_window_decoder;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        validU = 1'b0;
    logic        validS = 1'b0;
    logic        flush = 1'b0;
    logic        readyIn = 1'b1;
    logic [3:0]  dataIn = '0;

    logic        oReadyU, oValidU, oReadyS, oValidS;
    logic [15:0] oDataU, oDataS;

    int          errCount = 0;
    int          checkCount = 0;
    logic [15:0] qU[$];
    logic [15:0] qS[$];

    always #5 clk = ~clk;

    cbm_window_decoder #(.NH(2), .WR(8), .LOG_NT(4), .SIGNED(0), .DEPTH(2)) dutU (
        .iCLK                    (clk),
        .iRST                    (rstN),
        .iValid_AS_HiddenState   (validU),
        .oReady_AS_HiddenState   (oReadyU),
        .iData_AS_HiddenState    (dataIn),
        .iFlush                  (flush),
        .oValid_BM_DeHiddenState (oValidU),
        .iReady_BM_DeHiddenState (readyIn),
        .oData_BM_DeHiddenState  (oDataU)
    );

    cbm_window_decoder #(.NH(2), .WR(8), .LOG_NT(4), .SIGNED(1), .DEPTH(2)) dutS (
        .iCLK                    (clk),
        .iRST                    (rstN),
        .iValid_AS_HiddenState   (validS),
        .oReady_AS_HiddenState   (oReadyS),
        .iData_AS_HiddenState    (dataIn),
        .iFlush                  (flush),
        .oValid_BM_DeHiddenState (oValidS),
        .iReady_BM_DeHiddenState (readyIn),
        .oData_BM_DeHiddenState  (oDataS)
    );

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Words leave on the next rising edge when valid&&ready holds at the falling edge.
    always @(negedge clk) begin
        if (rstN && oValidU && readyIn) begin
            if (qU.size() == 0) checkValue("unexpected_word_u", 32'(oDataU), 32'hDEAD);
            else checkValue("word_u", 32'(oDataU), 32'(qU.pop_front()));
        end
        if (rstN && oValidS && readyIn) begin
            if (qS.size() == 0) checkValue("unexpected_word_s", 32'(oDataS), 32'hDEAD);
            else checkValue("word_s", 32'(oDataS), 32'(qS.pop_front()));
        end
    end

    task automatic sendBeat(input logic [3:0] d, input bit toS);
        int   waitCnt;
        logic rdy;
        waitCnt = 0;
        dataIn  = d;
        validU  = !toS;
        validS  = toS;
        forever begin
            @(negedge clk);
            rdy = toS ? oReadyS : oReadyU;
            @(posedge clk);
            #1;
            if (rdy) break;
            waitCnt++;
            if (waitCnt > 500) begin
                checkValue("beat_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        validU = 1'b0;
        validS = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while ((qU.size() != 0 || qS.size() != 0) && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkValue(tag, 32'(qU.size() + qS.size()), 32'd0);
    endtask

    initial begin
        #12;
        checkValue("rst_ready_u", 32'(oReadyU), 32'd1);
        checkValue("rst_valid_u", 32'(oValidU), 32'd0);
        checkValue("rst_data_u", 32'(oDataU), 32'd0);
        checkValue("rst_ready_s", 32'(oReadyS), 32'd1);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // T1: n0=01 every beat saturates, n1=00 stays zero
        readyIn = 1'b1;
        qU.push_back(16'h00FF);
        for (int i = 0; i < 16; i++) sendBeat(4'b0001, 1'b0);
        validU = 1'b0;
        checkValue("t1_valid_before_write", 32'(oValidU), 32'd0);
        @(posedge clk);
        #1;
        checkValue("t1_valid_after_write", 32'(oValidU), 32'd1);
        idle(2);
        drain("t1_drain");

        // T2: n0 alternates 01/11 (half count), n1=10 every beat
        qU.push_back(16'hFF80);
        for (int i = 0; i < 16; i++) sendBeat((i % 2 == 0) ? 4'b1001 : 4'b1011, 1'b0);
        idle(3);
        drain("t2_drain");

        // T3: bipolar, two back-to-back windows
        qS.push_back(16'h807F);
        qS.push_back(16'h0000);
        for (int i = 0; i < 16; i++) sendBeat(4'b0001, 1'b1);
        for (int i = 0; i < 8; i++) sendBeat(4'b0101, 1'b1);
        for (int i = 0; i < 8; i++) sendBeat(4'b0000, 1'b1);
        idle(3);
        drain("t3_drain");

        // T4: output stalled, three full windows
        readyIn = 1'b0;
        for (int i = 0; i < 3; i++) qU.push_back(16'hFFFF);
        for (int i = 0; i < 48; i++) sendBeat(4'b0101, 1'b0);
        idle(3);
        checkValue("t4_stall_ready", 32'(oReadyU), 32'd0);
        checkValue("t4_stall_valid", 32'(oValidU), 32'd1);
        checkValue("t4_queued", 32'(qU.size()), 32'd3);
        readyIn = 1'b1;
        @(posedge clk);
        #1;
        readyIn = 1'b0;
        checkValue("t4_push_on_pop", 32'(oReadyU), 32'd1);
        checkValue("t4_still_valid", 32'(oValidU), 32'd1);
        readyIn = 1'b1;
        drain("t4_drain");
        idle(1);
        checkValue("t4_empty", 32'(oValidU), 32'd0);

        // T5: flush after 5 beats, flush-cycle beat ignored
        for (int i = 0; i < 5; i++) sendBeat(4'b0101, 1'b0);
        dataIn = 4'b0101;
        validU = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        checkValue("t5_flush_ready", 32'(oReadyU), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        qU.push_back(16'h0000);
        for (int i = 0; i < 15; i++) sendBeat(4'b0000, 1'b0);
        idle(3);
        checkValue("t5_no_early_word", 32'(oValidU), 32'd0);
        sendBeat(4'b0000, 1'b0);
        idle(3);
        drain("t5_drain");

        // T6: asynchronous reset mid-window with a word held in the FIFO
        readyIn = 1'b0;
        for (int i = 0; i < 16; i++) sendBeat(4'b0101, 1'b0);
        idle(2);
        checkValue("t6_pre_valid", 32'(oValidU), 32'd1);
        for (int i = 0; i < 7; i++) sendBeat(4'b0101, 1'b0);
        validU = 1'b0;
        #3;
        rstN = 1'b0;
        #1;
        checkValue("t6_rst_valid", 32'(oValidU), 32'd0);
        checkValue("t6_rst_data", 32'(oDataU), 32'd0);
        checkValue("t6_rst_ready", 32'(oReadyU), 32'd1);
        #2;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        readyIn = 1'b1;
        qU.push_back(16'hFFFF);
        for (int i = 0; i < 16; i++) sendBeat(4'b0101, 1'b0);
        idle(3);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
